qclk_array: RTL and testbench
=============================

# qclk_array

Multi-channel qubit-timebase counter bank: `N_CHAN` independent free-running `WIDTH`-bit clocks, each with its own load path. Adds a global synchronous load for aligning all channels, a per-channel armed compare that emits a one-cycle fire pulse when the channel reaches a programmed time, and a per-channel wrap pulse. Sits beside the processor cores and supplies each core's timestamp and a scheduled-event trigger.

## Interface
Parameters:
- `WIDTH`, 32, counter width per channel
- `N_CHAN`, 4, number of channels (≥1)

Ports (channel i occupies bits `[i*WIDTH +: WIDTH]` of packed buses):
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `load_val`  in  N_CHAN*WIDTH  per-channel load value
- `load_en`  in  N_CHAN  per-channel load strobe
- `sync_load`  in  1  global load strobe, all channels
- `sync_val`  in  WIDTH  value for global load
- `cmp_val`  in  N_CHAN*WIDTH  per-channel compare value, sampled on arm
- `cmp_arm`  in  N_CHAN  latch `cmp_val[i]` and arm channel i
- `cmp_disarm`  in  N_CHAN  return channel i to IDLE
- `out`  out  N_CHAN*WIDTH  current counter values
- `cmp_armed`  out  N_CHAN  channel compare FSM is ARMED
- `cmp_fire`  out  N_CHAN  one-cycle pulse, aligned with `out[i]` == latched compare
- `wrap`  out  N_CHAN  one-cycle pulse, aligned with `out[i]` wrapping to 0

## Operation
- Reset (async assert, output effective immediately): all `out` = 0, compare registers = 0, FSMs IDLE, `cmp_armed`/`cmp_fire`/`wrap` = 0.
- Counter next value per channel, priority high→low: `sync_load` → `sync_val + 1`; `load_en[i]` → `load_val[i] + 1`; else `out[i] + 1`.
- The +1 on load keeps the convention that a loaded value denotes time at the load cycle; `out[i]` shows it one cycle on.
- Arithmetic modulo 2^WIDTH; `load_val`/`sync_val` all-ones loads 0.
- `wrap[i]` = 1 for the cycle in which `out[i]` becomes 0 through increment of all-ones only; loads and reset never raise `wrap`.
- Compare FSM per channel, states IDLE, ARMED:
  - `cmp_disarm[i]` → IDLE (wins over `cmp_arm[i]` in same cycle; no latch).
  - else `cmp_arm[i]` → latch `cmp_val[i]`, ARMED (re-arm while ARMED replaces the latched value).
  - ARMED and next counter value == latched value (compared against the register held before this edge) → `cmp_fire[i]` = 1 for the next cycle, FSM → IDLE.
  - Compare uses the chosen next value, so a load that lands exactly on the compare value fires; a load that jumps over it does not, and channel stays ARMED.
  - `cmp_arm[i]` in the same cycle as a match: new value latched, no fire from the old value, stays ARMED.
- `cmp_armed[i]` = registered FSM state.
- Channels are fully independent except for `sync_load`.

## Timing
- Load/sync latency: strobe in cycle t → `out` = value+1 in cycle t+1, value+2 in t+2.
- Arm in cycle t → `cmp_armed` = 1 from cycle t+1; earliest fire is cycle t+2 (a match in t+1 is not detected).
- `cmp_fire` and `out` = compare value are coincident; `cmp_armed` drops in the same cycle.
- `wrap` coincident with `out` = 0.
- Reset asserted mid-operation clears everything asynchronously; on deassert, counting resumes at 1 on the first edge.
- All outputs registered; no combinational input→output paths.

## Test plan
- Reset mid-count: run 10 cycles, assert `rst` between edges → `out` = 0 immediately; after release `out` = 1, 2, 3 on successive edges.
- Per-channel load: `load_en[1]`, `load_val[1]`=100 in cycle t → `out[1]`=101 at t+1, other channels unaffected; `sync_load`=1 with `sync_val`=500 in the same cycle → all channels 501.
- Compare fire: arm ch0 with 20 while `out[0]`=10 → `cmp_fire[0]` high exactly in the cycle `out[0]`=20, `cmp_armed[0]` low from then on; arm with value equal to `out[0]`+1 → no fire until wrap.
- Load skip: armed at 50, `load_en` with 60 → no fire, stays armed; later load with 49 → fire when `out`=50.
- Wrap: WIDTH=8, load 253 → `out` 254, 255, 0 with `wrap` high only at 0; load 255 → `out`=0 with `wrap` low.
- Arm/disarm conflict: `cmp_arm` and `cmp_disarm` both high → IDLE, no fire; arm in match cycle → no fire, new value armed.

Source files
------------

// File: rtl/qclk_array.sv
// Bank of N_CHAN free-running timebase counters, each with a private load path,
// a shared synchronous load, an armed compare that fires once, and a wrap pulse.
module qclk_array #(
  parameter int WIDTH  = 32,
  parameter int N_CHAN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CHAN*WIDTH-1:0] load_val,
  input  logic [N_CHAN-1:0]       load_en,
  input  logic                    sync_load,
  input  logic [WIDTH-1:0]        sync_val,
  input  logic [N_CHAN*WIDTH-1:0] cmp_val,
  input  logic [N_CHAN-1:0]       cmp_arm,
  input  logic [N_CHAN-1:0]       cmp_disarm,
  output logic [N_CHAN*WIDTH-1:0] out,
  output logic [N_CHAN-1:0]       cmp_armed,
  output logic [N_CHAN-1:0]       cmp_fire,
  output logic [N_CHAN-1:0]       wrap
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] arm_val;
    state_e           state_q, state_d;
    logic             fire_q, fire_d;
    logic             wrap_q, wrap_d;
    logic             match;

    assign ld_val  = load_val[i*WIDTH +: WIDTH];
    assign arm_val = cmp_val[i*WIDTH +: WIDTH];

    // A loaded value names the load cycle itself, hence the +1 on every path.
    always_comb begin
      cnt_d  = cnt_q + ONE;
      wrap_d = 1'b0;
      if (sync_load) begin
        cnt_d = sync_val + ONE;
      end else if (load_en[i]) begin
        cnt_d = ld_val + ONE;
      end else begin
        wrap_d = &cnt_q;
      end
    end

    // Compare against the value the counter is about to take, so exact loads fire.
    assign match = (cnt_d == cmp_q);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cmp_d   = cmp_q;
      if (cmp_disarm[i]) begin
        state_d = IDLE;
      end else if (cmp_arm[i]) begin
        state_d = ARMED;
        cmp_d   = arm_val;
      end else if (state_q == ARMED && match) begin
        state_d = IDLE;
      end
    end

    always_comb begin
      fire_d = (state_q == ARMED) && !cmp_disarm[i] && !cmp_arm[i] && match;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        cmp_q  <= '0;
        fire_q <= 1'b0;
        wrap_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        cmp_q  <= cmp_d;
        fire_q <= fire_d;
        wrap_q <= wrap_d;
      end
    end

    assign out[i*WIDTH +: WIDTH] = cnt_q;
    assign cmp_armed[i]          = (state_q == ARMED);
    assign cmp_fire[i]           = fire_q;
    assign wrap[i]               = wrap_q;
  end

endmodule

// File: tb/tb_qclk_array.sv
// Directed bench for qclk_array: a 32-bit 4-channel bank for load/compare paths
// and an 8-bit 2-channel bank where wrap-around is reachable in a few hundred cycles.
module tb_qclk_array;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] a_load_val = '0;
  logic [3:0]   a_load_en = '0;
  logic         a_sync_load = 1'b0;
  logic [31:0]  a_sync_val = '0;
  logic [127:0] a_cmp_val = '0;
  logic [3:0]   a_cmp_arm = '0;
  logic [3:0]   a_cmp_disarm = '0;
  logic [127:0] a_out;
  logic [3:0]   a_armed, a_fire, a_wrap;

  logic [15:0]  b_load_val = '0;
  logic [1:0]   b_load_en = '0;
  logic         b_sync_load = 1'b0;
  logic [7:0]   b_sync_val = '0;
  logic [15:0]  b_cmp_val = '0;
  logic [1:0]   b_cmp_arm = '0;
  logic [1:0]   b_cmp_disarm = '0;
  logic [15:0]  b_out;
  logic [1:0]   b_armed, b_fire, b_wrap;

  int n_cmp = 0;
  int n_bad = 0;

  qclk_array #(.WIDTH(32), .N_CHAN(4)) u_a (
    .clk(clk), .rst(rst), .load_val(a_load_val), .load_en(a_load_en),
    .sync_load(a_sync_load), .sync_val(a_sync_val), .cmp_val(a_cmp_val),
    .cmp_arm(a_cmp_arm), .cmp_disarm(a_cmp_disarm), .out(a_out),
    .cmp_armed(a_armed), .cmp_fire(a_fire), .wrap(a_wrap)
  );

  qclk_array #(.WIDTH(8), .N_CHAN(2)) u_b (
    .clk(clk), .rst(rst), .load_val(b_load_val), .load_en(b_load_en),
    .sync_load(b_sync_load), .sync_val(b_sync_val), .cmp_val(b_cmp_val),
    .cmp_arm(b_cmp_arm), .cmp_disarm(b_cmp_disarm), .out(b_out),
    .cmp_armed(b_armed), .cmp_fire(b_fire), .wrap(b_wrap)
  );

  // Inputs change right after the falling edge; outputs are read there too.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    step();
    step();
    n_cmp++;
    if (a_out !== '0 || a_armed !== '0 || a_fire !== '0 || a_wrap !== '0) begin
      n_bad++;
      $display("FAIL reset_a: out=%h armed=%b fire=%b wrap=%b required all zero", a_out, a_armed, a_fire, a_wrap);
    end
    n_cmp++;
    if (b_out !== '0 || b_armed !== '0 || b_fire !== '0 || b_wrap !== '0) begin
      n_bad++;
      $display("FAIL reset_b: out=%h armed=%b fire=%b wrap=%b required all zero", b_out, b_armed, b_fire, b_wrap);
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp = 32'(k);
      n_cmp++;
      if (a_out !== {4{exp}}) begin
        n_bad++;
        $display("FAIL reset_release_count: out=%h required all channels %0d", a_out, exp);
      end
    end
    for (int k = 0; k < 10; k++) step();
    n_cmp++;
    if (a_out[31:0] !== 32'd13) begin
      n_bad++;
      $display("FAIL run_before_reset: out0=%0d required 13", a_out[31:0]);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (a_out !== '0 || b_out !== '0) begin
      n_bad++;
      $display("FAIL async_reset: a_out=%h b_out=%h required 0", a_out, b_out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp = 32'(k);
      n_cmp++;
      if (a_out !== {4{exp}} || b_out !== {2{exp[7:0]}}) begin
        n_bad++;
        $display("FAIL reset_resume: a_out=%h b_out=%h required %0d", a_out, b_out, exp);
      end
    end
  endtask

  task automatic test_load();
    a_load_en[1] = 1'b1;
    a_load_val[32 +: 32] = 32'd100;
    step();
    a_load_en = '0;
    n_cmp++;
    if (a_out !== {32'd4, 32'd4, 32'd101, 32'd4}) begin
      n_bad++;
      $display("FAIL per_channel_load: out=%h required ch1=101 others=4", a_out);
    end
    a_sync_load = 1'b1;
    a_sync_val = 32'd500;
    a_load_en = 4'b1111;
    a_load_val = {4{32'd7}};
    step();
    a_sync_load = 1'b0;
    a_load_en = '0;
    n_cmp++;
    if (a_out !== {4{32'd501}}) begin
      n_bad++;
      $display("FAIL sync_load_priority: out=%h required all 501", a_out);
    end
    step();
    n_cmp++;
    if (a_out !== {4{32'd502}} || a_wrap !== '0) begin
      n_bad++;
      $display("FAIL after_sync: out=%h wrap=%b required all 502, no wrap", a_out, a_wrap);
    end
  endtask

  task automatic test_compare();
    logic [31:0] exp;
    a_load_en[0] = 1'b1;
    a_load_val[0 +: 32] = 32'd9;
    step();
    a_load_en = '0;
    a_cmp_arm[0] = 1'b1;
    a_cmp_val[0 +: 32] = 32'd20;
    step();
    a_cmp_arm = '0;
    n_cmp++;
    if (a_out[31:0] !== 32'd11 || a_armed[0] !== 1'b1 || a_fire[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL arm_ch0: out0=%0d armed=%b fire=%b required 11/1/0", a_out[31:0], a_armed[0], a_fire[0]);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      exp = 32'd12 + 32'(k);
      n_cmp++;
      if (a_out[31:0] !== exp || a_fire[0] !== (exp == 32'd20) || a_armed[0] !== (exp < 32'd20)) begin
        n_bad++;
        $display("FAIL compare_fire_ch0: out0=%0d fire=%b armed=%b required %0d/%b/%b",
                 a_out[31:0], a_fire[0], a_armed[0], exp, exp == 32'd20, exp < 32'd20);
      end
      n_cmp++;
      if (a_fire[3:1] !== 3'b000) begin
        n_bad++;
        $display("FAIL compare_independent: fire=%b required ch1..3 low", a_fire);
      end
    end
  endtask

  task automatic test_arm_next();
    int early, wraps, wrap_bad;
    logic fire_end;
    logic [7:0] exp;
    early = 0; wraps = 0; wrap_bad = 0; fire_end = 1'b0;
    b_load_en[0] = 1'b1;
    b_load_val[7:0] = 8'd99;
    step();
    b_load_en = '0;
    b_cmp_arm[0] = 1'b1;
    b_cmp_val[7:0] = 8'd101;
    step();
    b_cmp_arm = '0;
    n_cmp++;
    if (b_out[7:0] !== 8'd101 || b_armed[0] !== 1'b1 || b_fire[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL arm_next_value: out0=%0d armed=%b fire=%b required 101/1/0", b_out[7:0], b_armed[0], b_fire[0]);
    end
    for (int k = 1; k <= 256; k++) begin
      step();
      exp = 8'(101 + k);
      if (k != 256 && b_fire[0] === 1'b1) early++;
      if (k == 256) fire_end = b_fire[0];
      if (b_wrap[0] === 1'b1) wraps++;
      if (b_wrap[0] !== (exp == 8'd0) || b_out[7:0] !== exp) wrap_bad++;
    end
    n_cmp++;
    if (early !== 0 || fire_end !== 1'b1) begin
      n_bad++;
      $display("FAIL fire_after_wrap: early_fires=%0d final_fire=%b required 0/1", early, fire_end);
    end
    n_cmp++;
    if (wraps !== 1 || wrap_bad !== 0) begin
      n_bad++;
      $display("FAIL wrap_during_run: wraps=%0d bad_cycles=%0d required 1/0", wraps, wrap_bad);
    end
  endtask

  task automatic test_load_skip();
    a_load_en[2] = 1'b1;
    a_load_val[64 +: 32] = 32'd39;
    step();
    a_load_en = '0;
    a_cmp_arm[2] = 1'b1;
    a_cmp_val[64 +: 32] = 32'd50;
    step();
    a_cmp_arm = '0;
    a_load_en[2] = 1'b1;
    a_load_val[64 +: 32] = 32'd60;
    step();
    a_load_en = '0;
    n_cmp++;
    if (a_out[64 +: 32] !== 32'd61 || a_fire[2] !== 1'b0 || a_armed[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL load_skip: out2=%0d fire=%b armed=%b required 61/0/1", a_out[64 +: 32], a_fire[2], a_armed[2]);
    end
    step();
    a_load_en[2] = 1'b1;
    a_load_val[64 +: 32] = 32'd49;
    step();
    a_load_en = '0;
    n_cmp++;
    if (a_out[64 +: 32] !== 32'd50 || a_fire[2] !== 1'b1 || a_armed[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL load_exact_fire: out2=%0d fire=%b armed=%b required 50/1/0", a_out[64 +: 32], a_fire[2], a_armed[2]);
    end
    step();
    n_cmp++;
    if (a_fire[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL fire_one_cycle: fire2=%b required 0", a_fire[2]);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_out [4];
    logic       exp_wrap [4];
    exp_out = '{8'd254, 8'd255, 8'd0, 8'd1};
    exp_wrap = '{1'b0, 1'b0, 1'b1, 1'b0};
    b_load_en[1] = 1'b1;
    b_load_val[15:8] = 8'd253;
    for (int k = 0; k < 4; k++) begin
      step();
      b_load_en = '0;
      n_cmp++;
      if (b_out[15:8] !== exp_out[k] || b_wrap[1] !== exp_wrap[k]) begin
        n_bad++;
        $display("FAIL wrap_seq: out1=%0d wrap=%b required %0d/%b", b_out[15:8], b_wrap[1], exp_out[k], exp_wrap[k]);
      end
    end
    b_load_en[1] = 1'b1;
    b_load_val[15:8] = 8'd255;
    step();
    b_load_en = '0;
    n_cmp++;
    if (b_out[15:8] !== 8'd0 || b_wrap[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL load_ones_no_wrap: out1=%0d wrap=%b required 0/0", b_out[15:8], b_wrap[1]);
    end
  endtask

  task automatic test_conflict();
    a_load_en[3] = 1'b1;
    a_load_val[96 +: 32] = 32'd9;
    step();
    a_load_en = '0;
    a_cmp_arm[3] = 1'b1;
    a_cmp_disarm[3] = 1'b1;
    a_cmp_val[96 +: 32] = 32'd12;
    step();
    a_cmp_arm = '0;
    a_cmp_disarm = '0;
    n_cmp++;
    if (a_out[96 +: 32] !== 32'd11 || a_armed[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL arm_disarm_conflict: out3=%0d armed=%b required 11/0", a_out[96 +: 32], a_armed[3]);
    end
    step();
    n_cmp++;
    if (a_fire[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL conflict_no_fire: fire3=%b required 0 at out3=%0d", a_fire[3], a_out[96 +: 32]);
    end
    a_cmp_arm[3] = 1'b1;
    a_cmp_val[96 +: 32] = 32'd20;
    step();
    a_cmp_arm = '0;
    for (int k = 0; k < 6; k++) step();
    a_cmp_arm[3] = 1'b1;
    a_cmp_val[96 +: 32] = 32'd30;
    step();
    a_cmp_arm = '0;
    n_cmp++;
    if (a_out[96 +: 32] !== 32'd20 || a_fire[3] !== 1'b0 || a_armed[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL rearm_in_match: out3=%0d fire=%b armed=%b required 20/0/1", a_out[96 +: 32], a_fire[3], a_armed[3]);
    end
    for (int k = 0; k < 10; k++) step();
    n_cmp++;
    if (a_out[96 +: 32] !== 32'd30 || a_fire[3] !== 1'b1 || a_armed[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL rearm_fire: out3=%0d fire=%b armed=%b required 30/1/0", a_out[96 +: 32], a_fire[3], a_armed[3]);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_compare();
    test_arm_next();
    test_load_skip();
    test_wrap();
    test_conflict();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
